pipe_stage_buffer: RTL and testbench
====================================

# pipe_stage_buffer

Parametrised elastic pipeline stage register, the successor to the fixed-field inter-stage registers between MIPS pipeline stages. It carries an opaque data payload and a control bundle from one stage to the next. It adds a valid/ready handshake and a 2-entry skid buffer, so back-pressure never creates a combinational ready path. A synchronous flush turns all in-flight entries into bubbles with zeroed control. One instance sits on each stage boundary (F/D, D/E, E/M, M/W).

## Interface
- DATA_WIDTH, 64: payload width (operands, immediate, register addresses, packed by the parent).
- CTRL_WIDTH, 8: control bundle width (RegWrite, MemWrite, ALUControl, …); zeroed on bubble/flush.
- COUNT_WIDTH, 16: width of the performance counters (only with the macro).

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  reset, asynchronous, active-low.
- i_CLR  in  1  synchronous flush.
- i_Valid  in  1  upstream has an entry.
- o_Ready  out  1  stage can accept an entry.
- i_Data  in  DATA_WIDTH  upstream payload.
- i_Ctrl  in  CTRL_WIDTH  upstream control.
- o_Valid  out  1  entry presented downstream.
- i_Ready  in  1  downstream accepts.
- o_Data  out  DATA_WIDTH  payload to downstream.
- o_Ctrl  out  CTRL_WIDTH  control to downstream.
- o_StallCnt  out  COUNT_WIDTH  cycles with o_Valid=1, i_Ready=0 (macro only).
- o_BubbleCnt  out  COUNT_WIDTH  cycles with o_Valid=0, i_Ready=1 (macro only).

## Operation
- Signal definitions:
  - accept = i_Valid & o_Ready.
  - send = o_Valid & i_Ready.
  - Storage is a main register (drives o_Data/o_Ctrl) plus a skid register.
- States:
  - EMPTY: o_Valid=0, o_Ready=1.
  - ONE: main valid, o_Ready=1.
  - FULL: main and skid valid, o_Ready=0.
- Transitions:
  - EMPTY, accept → ONE; main ← input.
  - ONE, accept & send → ONE; main ← input.
  - ONE, accept & !send → FULL; skid ← input.
  - ONE, !accept & send → EMPTY.
  - ONE, neither → ONE.
  - FULL, send → ONE; main ← skid.
  - FULL, !send → FULL. No accept is possible in FULL.
- Ordering: entries leave strictly in arrival order. Payload and control are never modified in transit.
- Bubble rule: whenever the state is EMPTY, o_Ctrl = 0. o_Data holds its last value and is don't-care.
- Flush: i_CLR has priority over all transitions and forces the next state to EMPTY.
  - main and skid control are zeroed.
  - An input accepted in the flush cycle is discarded.
  - o_Ready is still 1 in that cycle if the state allows; upstream is flushed by the same hazard unit.
- Reset, including mid-operation: state EMPTY, o_Valid=0, o_Ready=1, o_Data=0, o_Ctrl=0, skid=0, counters=0.

## Timing
- Latency: 1 cycle from accept to o_Valid when EMPTY or on pass-through.
- Throughput: 1 entry per cycle under continuous i_Ready=1.
- o_Ready is a function of registered state only; there is no combinational path from i_Ready to o_Ready.
- o_Valid, o_Data and o_Ctrl are registered outputs.
- Back-pressure: when i_Ready deasserts, one extra entry is absorbed into skid. o_Ready falls in the following cycle.
- i_CLR effect is visible on the next clock edge. o_Valid=0 the cycle after the flush.
- Counters:
  - Each counts once per qualifying cycle.
  - Each saturates at 2^COUNT_WIDTH−1.
  - Cleared by reset only; not cleared by flush.

## Configuration
- PIPE_STAGE_PERF_EN
  - Defined: o_StallCnt and o_BubbleCnt are present and counting.
  - Undefined: both ports are absent and no counter logic is synthesised. Handshake behaviour is identical either way.

## Structure
- Shared package pipe_pkg:
  - State enum (EMPTY=2'b00, ONE=2'b01, FULL=2'b11).
  - Default widths.
  - Per-boundary CTRL_WIDTH constants for F/D, D/E, E/M and M/W.
- Sub-module pipe_perf_counter: saturating counter with increment enable, instantiated twice under the macro.

## Test plan
- Reset mid-stream, with state FULL and i_RST asserted low → o_Valid=0, o_Ready=1, o_Data=0, o_Ctrl=0 immediately; counters=0.
- Streaming: i_Ready=1, i_Valid=1, data 0x1..0x8 on consecutive cycles → o_Data 0x1..0x8 one cycle later, o_Valid continuous, no gaps.
- Back-pressure: stream 0xA,0xB,0xC, drop i_Ready after 0xA is presented → 0xB held in main, 0xC in skid, o_Ready=0. Raise i_Ready → 0xB then 0xC delivered, with no loss or duplication.
- Flush in FULL, with i_CLR=1 and i_Valid=1 carrying 0xD → next cycle o_Valid=0, o_Ctrl=0, state EMPTY. 0xD is never delivered.
- Bubble control: i_Valid=0 for 3 cycles after ctrl 0xFF → o_Ctrl=0x00 while o_Valid=0.
- With PIPE_STAGE_PERF_EN and COUNT_WIDTH=4: 20 stall cycles → o_StallCnt=15 (saturated). A subsequent i_CLR leaves the count at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: state encoding,
// default widths and the per-boundary control bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } pipe_state_e;

    localparam int unsigned PIPE_DATA_WIDTH  = 64;
    localparam int unsigned PIPE_CTRL_WIDTH  = 8;
    localparam int unsigned PIPE_COUNT_WIDTH = 16;

    localparam int unsigned FD_CTRL_WIDTH = 1;
    localparam int unsigned DE_CTRL_WIDTH = 10;
    localparam int unsigned EM_CTRL_WIDTH = 4;
    localparam int unsigned MW_CTRL_WIDTH = 2;

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating event counter with increment enable; cleared only by reset.
module pipe_perf_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_En,
    output logic [WIDTH-1:0] o_Count
);

    localparam logic [WIDTH-1:0] INC = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_En && (count_q != '1)) begin
            count_d = count_q + INC;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Count = count_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add the stall/bubble performance counters.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = PIPE_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH  = PIPE_CTRL_WIDTH
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned COUNT_WIDTH = PIPE_COUNT_WIDTH
`endif
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   i_CLR,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    input  logic [DATA_WIDTH-1:0]  i_Data,
    input  logic [CTRL_WIDTH-1:0]  i_Ctrl,
    output logic                   o_Valid,
    input  logic                   i_Ready,
    output logic [DATA_WIDTH-1:0]  o_Data,
    output logic [CTRL_WIDTH-1:0]  o_Ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [COUNT_WIDTH-1:0] o_StallCnt,
    output logic [COUNT_WIDTH-1:0] o_BubbleCnt
`endif
);

    pipe_state_e           state_q,     state_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;

    logic accept;
    logic send;

    // The state encoding makes valid and ready single flop bits, so neither
    // depends combinationally on i_Ready.
    assign o_Valid = state_q[0];
    assign o_Ready = ~state_q[1];

    assign accept = i_Valid & o_Ready;
    assign send   = o_Valid & i_Ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d     = ST_ONE;
                    main_data_d = i_Data;
                    main_ctrl_d = i_Ctrl;
                end
            end
            ST_ONE: begin
                if (accept && send) begin
                    main_data_d = i_Data;
                    main_ctrl_d = i_Ctrl;
                end else if (accept) begin
                    state_d     = ST_FULL;
                    skid_data_d = i_Data;
                    skid_ctrl_d = i_Ctrl;
                end else if (send) begin
                    // Draining to EMPTY leaves a bubble, so control goes to zero.
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                end
            end
            ST_FULL: begin
                if (send) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
            end
        endcase

        if (i_CLR) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = '0;
            skid_data_d = skid_data_q;
            skid_ctrl_d = '0;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign o_Data = main_data_q;
    assign o_Ctrl = main_ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_stall_cnt (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_En    (o_Valid & ~i_Ready),
        .o_Count (o_StallCnt)
    );

    pipe_perf_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_bubble_cnt (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_En    (~o_Valid & i_Ready),
        .o_Count (o_BubbleCnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_pipe_stage_buffer;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 8;
    localparam int unsigned NW = 4;
    localparam int unsigned MAXC = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          out_ready_dut;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          ds_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(
        .DATA_WIDTH  (DW),
        .CTRL_WIDTH  (CW)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .COUNT_WIDTH (NW)
`endif
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst_n),
        .i_CLR       (clr),
        .i_Valid     (in_valid),
        .o_Ready     (out_ready_dut),
        .i_Data      (in_data),
        .i_Ctrl      (in_ctrl),
        .o_Valid     (out_valid),
        .i_Ready     (ds_ready),
        .o_Data      (out_data),
        .o_Ctrl      (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .o_StallCnt  (stall_cnt),
        .o_BubbleCnt (bubble_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity two.
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t        mq[$];
    int unsigned stall_m;
    int unsigned bubble_m;
    bit          m_valid, m_ready, m_send, m_accept;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            stall_m  = 0;
            bubble_m = 0;
        end else begin
            m_valid  = mq.size() > 0;
            m_ready  = mq.size() < 2;
            m_send   = m_valid && ds_ready;
            m_accept = in_valid && m_ready;
            if (m_valid && !ds_ready && stall_m < MAXC) stall_m++;
            if (!m_valid && ds_ready && bubble_m < MAXC) bubble_m++;
            if (clr) begin
                mq.delete();
            end else begin
                if (m_send) void'(mq.pop_front());
                if (m_accept) mq.push_back('{d: in_data, c: in_ctrl});
            end
        end
    end

    // Entries the DUT actually hands downstream.
    logic [DW-1:0] dlog[$];
    always @(posedge clk) begin
        if (rst_n && out_valid && ds_ready) dlog.push_back(out_data);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("model_ready", 64'(out_ready_dut), 64'(mq.size() < 2));
            check("model_ctrl", 64'(out_ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'h0);
            if (mq.size() > 0) check("model_data", out_data, mq[0].d);
`ifdef PIPE_STAGE_PERF_EN
            check("model_stall_cnt", 64'(stall_cnt), 64'(stall_m));
            check("model_bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
`endif
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic rdy, input logic fl);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        ds_ready = rdy;
        clr      = fl;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'h0);
        check({tag, "_ready"}, 64'(out_ready_dut), 64'h1);
        check({tag, "_data"}, out_data, 64'h0);
        check({tag, "_ctrl"}, 64'(out_ctrl), 64'h0);
`ifdef PIPE_STAGE_PERF_EN
        check({tag, "_stallcnt"}, 64'(stall_cnt), 64'h0);
        check({tag, "_bubblecnt"}, 64'(bubble_cnt), 64'h0);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_ctrl  = '0;
        ds_ready = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Streaming 1..8 with downstream always ready.
        dlog.delete();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'(i), 8'(8'h10 + i), 1'b1, 1'b0);
            check("stream_valid", 64'(out_valid), 64'h1);
            check("stream_data", out_data, 64'(i));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_count", 64'(dlog.size()), 64'd8);
        for (int i = 0; i < 8 && i < dlog.size(); i++) check("stream_order", dlog[i], 64'(i + 1));

        // Back-pressure: A delivered, B held in main, C absorbed into skid.
        dlog.delete();
        step(1'b1, 64'hA, 8'h01, 1'b1, 1'b0);
        step(1'b1, 64'hB, 8'h02, 1'b1, 1'b0);
        step(1'b1, 64'hC, 8'h03, 1'b0, 1'b0);
        check("bp_ready_low", 64'(out_ready_dut), 64'h0);
        check("bp_main_b", out_data, 64'hB);
        check("bp_ctrl_b", 64'(out_ctrl), 64'h02);
        step(1'b1, 64'hEE, 8'hEE, 1'b0, 1'b0);
        check("bp_hold_b", out_data, 64'hB);
        check("bp_hold_ready", 64'(out_ready_dut), 64'h0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("bp_then_c", out_data, 64'hC);
        check("bp_ready_back", 64'(out_ready_dut), 64'h1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("bp_count", 64'(dlog.size()), 64'd3);
        if (dlog.size() == 3) begin
            check("bp_order0", dlog[0], 64'hA);
            check("bp_order1", dlog[1], 64'hB);
            check("bp_order2", dlog[2], 64'hC);
        end

        // Flush while FULL with a new input offered.
        dlog.delete();
        step(1'b1, 64'h21, 8'h21, 1'b0, 1'b0);
        step(1'b1, 64'h22, 8'h22, 1'b0, 1'b0);
        check("fl_full", 64'(out_ready_dut), 64'h0);
        step(1'b1, 64'hD, 8'h55, 1'b0, 1'b1);
        check("fl_valid", 64'(out_valid), 64'h0);
        check("fl_ctrl", 64'(out_ctrl), 64'h0);
        check("fl_ready", 64'(out_ready_dut), 64'h1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("fl_nothing_sent", 64'(dlog.size()), 64'd0);

        // Bubble control after a full-ones control word.
        step(1'b1, 64'h77, 8'hFF, 1'b1, 1'b0);
        check("bub_ctrl_ff", 64'(out_ctrl), 64'hFF);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            check("bub_valid", 64'(out_valid), 64'h0);
            check("bub_ctrl", 64'(out_ctrl), 64'h0);
        end

        // Asynchronous reset mid-stream while FULL.
        step(1'b1, 64'h31, 8'h05, 1'b0, 1'b0);
        step(1'b1, 64'h32, 8'h06, 1'b0, 1'b0);
        check("mid_full", 64'(out_ready_dut), 64'h0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter saturation and insensitivity to flush.
        step(1'b1, 64'h41, 8'h09, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        check("stall_sat", 64'(stall_cnt), 64'd15);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("stall_after_flush", 64'(stall_cnt), 64'd15);
        check("stall_flush_valid", 64'(out_valid), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
